// File: rtl/fir_inv_iir.sv
// -----------------------------------------------------------------------------
// fir_inv_iir
//   Recursive inverse (deconvolution) filter for a 3-tap Q4.4 FIR
//   y[n] = a*x[n] + b*x[n-1] + c*x[n-2]. Reconstructs
//   x[n] = (y[n] - b*x[n-1] - c*x[n-2]) * (1/a), where the host supplies 1/a.
//   One shared signed multiplier is time-multiplexed by a 4-state FSM
//   (IDLE -> MB -> MC -> SC), giving one sample every 4 cycles.
//
//   Optional feature macro: INV_SAT_EN
//     defined   : result is clipped to [-128, 127] and sat flags the clip
//     undefined : result wraps (two's-complement truncation), sat tied to 0
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous reset, active low (0 = reset)
//   ainv       in   8  1/a, signed Q4.4
//   b          in   8  tap-1 coefficient, signed Q4.4
//   c          in   8  tap-2 coefficient, signed Q4.4
//   y_in       in   8  FIR output sample, signed Q4.4
//   in_valid   in   1  y_in / coefficients valid
//   in_ready   out  1  block can accept a sample (FSM in IDLE)
//   x_out      out  8  reconstructed sample, signed Q4.4
//   out_valid  out  1  one-cycle pulse, x_out updated
//   sat        out  1  x_out was clipped (0 when INV_SAT_EN is undefined)
// -----------------------------------------------------------------------------
module fir_inv_iir (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] ainv,
  input  logic signed [7:0] b,
  input  logic signed [7:0] c,
  input  logic signed [7:0] y_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic signed [7:0] x_out,
  output logic              out_valid,
  output logic              sat
);

  typedef enum logic [1:0] {IDLE, MB, MC, SC} state_t;

  state_t             state;
  logic signed [17:0] acc;      // Q10.8
  logic signed [7:0]  x1;       // x[n-1]
  logic signed [7:0]  x2;       // x[n-2]
  logic signed [7:0]  ainv_q;
  logic signed [7:0]  b_q;
  logic signed [7:0]  c_q;

  logic signed [17:0] mul_a;
  logic signed [7:0]  mul_b;
  logic signed [25:0] prod;
  logic signed [17:0] r;        // Q.4 result before fitting to 8 bits

  // Fit the scaled result into 8 bits: clip when saturation is built,
  // otherwise keep the low byte.
  function automatic logic signed [7:0] fit8(input logic signed [17:0] v);
`ifdef INV_SAT_EN
    if (v > 18'sd127)
      fit8 = 8'sh7F;
    else if (v < -18'sd128)
      fit8 = 8'sh80;
    else
      fit8 = 8'(v);
`else
    fit8 = 8'(v);
`endif
  endfunction

`ifdef INV_SAT_EN
  function automatic logic clip8(input logic signed [17:0] v);
    clip8 = (v > 18'sd127) || (v < -18'sd128);
  endfunction
`endif

  // Shared multiplier operand select. In MB/MC the 8x8 history product is
  // subtracted from acc; in SC acc itself is scaled by 1/a.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MB: begin
        mul_a = {{10{x1[7]}}, x1};
        mul_b = b_q;
      end
      MC: begin
        mul_a = {{10{x2[7]}}, x2};
        mul_b = c_q;
      end
      SC: begin
        mul_a = acc;
        mul_b = ainv_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign prod = mul_a * mul_b;
  // Q.12 product back to Q.4 with an arithmetic (flooring) shift.
  assign r    = 18'(prod >>> 8);

  assign in_ready = (state == IDLE);

  // Coefficients are captured only at acceptance so mid-sample changes
  // on the inputs cannot disturb the sample in flight.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      ainv_q <= ainv;
      b_q    <= b;
      c_q    <= c;
    end
  end

  // IDLE: accept; MB: subtract b*x1; MC: subtract c*x2; SC: scale and emit
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      x1        <= '0;
      x2        <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Q4.4 -> Q10.8
            acc   <= {{6{y_in[7]}}, y_in, 4'b0000};
            state <= MB;
          end
        end
        MB: begin
          acc   <= acc - 18'(prod);
          state <= MC;
        end
        MC: begin
          acc   <= acc - 18'(prod);
          state <= SC;
        end
        SC: begin
          // History takes the fitted value so the recursion tracks what
          // was actually output.
          x_out     <= fit8(r);
          x1        <= fit8(r);
          x2        <= x1;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INV_SAT_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (!rst)
      sat_q <= 1'b0;
    else if (state == SC)
      sat_q <= clip8(r);
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

endmodule
